// File: rtl/zrle_encoder.sv
// Zero-run-length encoder: packs zero/non-zero symbols of a word stream into
// DATA_W-bit znz words, padding and tagging the final word of each block.
module zrle_encoder #(
  parameter int DATA_W = 8,
  parameter int ZRUN_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] znz_o,
  output logic              znz_last_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i
);

  localparam int ACC_W  = DATA_W + ZRUN_W + 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int SYM_W  = ZRUN_W + 2;
  localparam logic [FILL_W-1:0] FILL_DW  = FILL_W'(DATA_W);
  localparam logic [FILL_W-1:0] FILL_ACC = FILL_W'(ACC_W);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic                run_act_q, run_act_d;
  logic [ZRUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   znz_q, znz_d;
  logic                znz_last_q, znz_last_d;
  logic                znz_vld_q, znz_vld_d;

  logic                in_hs, out_hs;
  logic [ZRUN_W-1:0]   cnt_new;
  logic [SYM_W-1:0]    sym_bits;
  logic [FILL_W-1:0]   sym_len;
  logic [DATA_W-1:0]   pad_mask;

  assign in_hs  = vld_i & rdy_q;
  assign out_hs = znz_vld_q & znz_rdy_i;

  always_comb begin
    state_d   = state_q;
    run_act_d = run_act_q;
    run_cnt_d = run_cnt_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    cnt_new   = '0;
    sym_bits  = '0;
    sym_len   = '0;

    if (in_hs) begin
      if (|data_i) begin
        if (run_act_q) begin
          sym_bits = {1'b0, run_cnt_q, 1'b1};
          sym_len  = FILL_W'(SYM_W);
        end else begin
          sym_bits = SYM_W'(1);
          sym_len  = FILL_W'(1);
        end
        run_act_d = 1'b0;
      end else begin
        cnt_new   = run_act_q ? run_cnt_q + ZRUN_W'(1) : '0;
        run_cnt_d = cnt_new;
        // A full-length run or the end of the block closes the run right away.
        if ((&cnt_new) || last_i) begin
          sym_bits  = SYM_W'({1'b0, cnt_new});
          sym_len   = FILL_W'(ZRUN_W + 1);
          run_act_d = 1'b0;
        end else begin
          run_act_d = 1'b1;
        end
      end
      acc_d  = acc_q | ((ACC_W'(sym_bits) << (FILL_ACC - sym_len)) >> fill_q);
      fill_d = fill_q + sym_len;
      if (last_i) state_d = S_FLUSH;
    end else if (out_hs) begin
      acc_d  = acc_q << DATA_W;
      fill_d = (fill_q > FILL_DW) ? fill_q - FILL_DW : '0;
      if (znz_last_q) begin
        state_d   = S_RUN;
        fill_d    = '0;
        run_act_d = 1'b0;
        acc_d     = '0;
      end
    end

    // Outputs are precomputed from next state so they leave the block registered.
    pad_mask   = (fill_d >= FILL_DW) ? '1 : ~({DATA_W{1'b1}} >> fill_d);
    znz_d      = acc_d[ACC_W-1 -: DATA_W] & pad_mask;
    znz_vld_d  = (state_d == S_FLUSH) || (fill_d >= FILL_DW);
    znz_last_d = (state_d == S_FLUSH) && (fill_d <= FILL_DW);
    rdy_d      = (state_d == S_RUN) && (fill_d < FILL_DW);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RUN;
      run_act_q  <= 1'b0;
      run_cnt_q  <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
      rdy_q      <= 1'b1;
      znz_q      <= '0;
      znz_last_q <= 1'b0;
      znz_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_act_q  <= run_act_d;
      run_cnt_q  <= run_cnt_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      rdy_q      <= rdy_d;
      znz_q      <= znz_d;
      znz_last_q <= znz_last_d;
      znz_vld_q  <= znz_vld_d;
    end
  end

  assign rdy_o      = rdy_q;
  assign znz_o      = znz_q;
  assign znz_last_o = znz_last_q;
  assign znz_vld_o  = znz_vld_q;

endmodule

// File: tb/tb_zrle_encoder.sv
// Directed table-driven bench for zrle_encoder with DATA_W=8, ZRUN_W=4.
module tb_zrle_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic       last = 1'b0;
  logic       vld = 1'b0;
  logic       rdy;
  logic [7:0] znz;
  logic       znz_last;
  logic       znz_vld;
  logic       znz_rdy = 1'b1;

  int total = 0;
  int bad = 0;
  logic [8:0] rx_q[$];
  logic       got_last = 1'b0;

  always #5 clk = ~clk;

  zrle_encoder #(.DATA_W(8), .ZRUN_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .last_i(last), .vld_i(vld),
    .rdy_o(rdy), .znz_o(znz), .znz_last_o(znz_last), .znz_vld_o(znz_vld),
    .znz_rdy_i(znz_rdy)
  );

  typedef struct {
    int          n_words;
    logic [31:0] nz_mask;
    int          n_out;
    logic [1:0][7:0] exp_w;
    logic [1:0]  exp_l;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: record every output handshake, and check input/output exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      check("vld_rdy_excl", {31'd0, znz_vld & rdy}, 32'd0);
      if (znz_vld && znz_rdy) begin
        rx_q.push_back({znz_last, znz});
        $display("out word=%02h last=%0b", znz, znz_last);
        if (znz_last) got_last = 1'b1;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the input handshake.
  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    vld = 1'b1; data = d; last = l;
    while (rdy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout: got rdy=%0b want 1", rdy);
    end
    @(negedge clk);
    vld = 1'b0; last = 1'b0; data = '0;
  endtask

  task automatic wait_last();
    int t = 0;
    while (!got_last && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!got_last) begin
      total++; bad++;
      $display("FAIL last_timeout: got no last word want one");
    end
    @(negedge clk);
    check("rdy_after_last", {31'd0, rdy}, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    rx_q.delete();
    got_last = 1'b0;
    for (int i = 0; i < v.n_words; i++)
      send(v.nz_mask[i] ? 8'((i * 37) % 255 + 1) : 8'h00, i == v.n_words - 1);
    wait_last();
    check($sformatf("v%0d_count", idx), rx_q.size(), v.n_out);
    for (int k = 0; k < v.n_out && k < rx_q.size(); k++) begin
      check($sformatf("v%0d_w%0d", idx, k), {23'd0, rx_q[k]}, {23'd0, v.exp_l[k], v.exp_w[k]});
    end
  endtask

  initial begin
    vecs[0] = '{8,  32'h0000_00FF, 1, {8'h00, 8'hFF}, 2'b01};
    vecs[1] = '{4,  32'h0000_0009, 1, {8'h00, 8'h86}, 2'b01};
    vecs[2] = '{17, 32'h0001_0000, 1, {8'h00, 8'h7C}, 2'b01};
    vecs[3] = '{17, 32'h0000_0000, 2, {8'h00, 8'h78}, 2'b10};
    vecs[4] = '{1,  32'h0000_0000, 1, {8'h00, 8'h00}, 2'b01};
    vecs[5] = '{1,  32'h0000_0001, 1, {8'h00, 8'h80}, 2'b01};
    vecs[6] = '{4,  32'h0000_0005, 2, {8'h00, 8'h82}, 2'b10};
    vecs[7] = '{32, 32'h0000_0000, 2, {8'hC0, 8'h7B}, 2'b10};

    repeat (2) @(negedge clk);
    check("rst_vld", {31'd0, znz_vld}, 32'd0);
    check("rst_last", {31'd0, znz_last}, 32'd0);
    check("rst_znz", {24'd0, znz}, 32'd0);
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Output stall: 8 non-zero words fill one word, 9th closes the block.
    rx_q.delete();
    got_last = 1'b0;
    znz_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0);
    check("stall_rdy", {31'd0, rdy}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      check("stall_vld", {31'd0, znz_vld}, 32'd1);
      check("stall_word", {23'd0, znz_last, znz}, {23'd0, 1'b0, 8'hFF});
      @(negedge clk);
    end
    znz_rdy = 1'b1;
    send(8'h5A, 1'b1);
    wait_last();
    check("stall_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("stall_w0", {23'd0, rx_q[0]}, {23'd0, 1'b0, 8'hFF});
      check("stall_w1", {23'd0, rx_q[1]}, {23'd0, 1'b1, 8'h80});
    end

    // Reset mid-block discards buffered bits.
    rx_q.delete();
    for (int i = 0; i < 3; i++) send(8'hA5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, znz_vld}, 32'd0);
    check("mid_rst_last", {31'd0, znz_last}, 32'd0);
    check("mid_rst_znz", {24'd0, znz}, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
